// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared CPU package: hazard-controller FSM states and the tracking-entry
// record that follows each instruction through ID/EX, EX/MEM and MEM/WB.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       is_halt;
    } track_entry_t;

    localparam track_entry_t ENTRY_EMPTY = '0;

endpackage

// File: rtl/hazard_track_entry.sv
// One pipeline tracking register: holds the destination/control summary
// of the instruction currently in a stage; a bubble squashes it to empty.
module hazard_track_entry
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         bubble,
    input  track_entry_t d,
    output track_entry_t q
);

    // Bubble wins over load so a squashed slot can never carry a stale rd.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= ENTRY_EMPTY;
        end else if (bubble) begin
            q <= ENTRY_EMPTY;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall detection, mispredict flush,
// halt drain sequencing and destination tracking for the forwarding unit.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int          NUM_STAGES_DRAIN = 3,
    parameter logic [31:0] STALL_CNT_RESET  = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_is_halt,
    input  logic        ex_flush,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic [4:0]  ex_mem_rd,
    output logic        ex_mem_reg_write,
    output logic [4:0]  mem_wb_rd,
    output logic        mem_wb_reg_write,
    output logic        halted,
    output logic [31:0] stall_cycles
);

    localparam logic [7:0] DRAIN_LAST = 8'(NUM_STAGES_DRAIN - 1);

    hz_state_e    state;
    logic [7:0]   drain_cnt;
    track_entry_t id_entry;
    track_entry_t id_ex_q;
    track_entry_t ex_mem_q;
    track_entry_t mem_wb_q;
    logic         running;
    logic         hazard;
    logic         stall;
    logic         flush;
    logic         halt_accept;
    logic         halt_retired;
    logic         unused_bits;

    assign id_entry = '{valid: id_valid, rd: id_rd, reg_write: id_reg_write,
                        mem_read: id_mem_read, is_halt: id_is_halt};

    // Load-use detection; a flush or a non-RUN state overrides any hazard.
    always_comb begin
        running = (state == ST_RUN);
        hazard  = id_valid && id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd != 5'd0) &&
                  ((id_use_rs1 && (id_rs1 == id_ex_q.rd)) ||
                   (id_use_rs2 && (id_rs2 == id_ex_q.rd)));
        flush        = running && ex_flush;
        stall        = running && !ex_flush && hazard;
        halt_accept  = running && id_valid && id_is_halt && !stall && !ex_flush;
        halt_retired = (mem_wb_q.valid && mem_wb_q.is_halt) || (drain_cnt == DRAIN_LAST);
    end

    // Pipeline-register enables and squash controls for the current cycle.
    always_comb begin
        pc_write     = running && !stall;
        if_id_write  = running && !stall;
        if_id_flush  = flush;
        id_ex_bubble = stall || flush || !running;
    end

    hazard_track_entry u_id_ex (
        .clk(clk), .reset(reset), .load(1'b1), .bubble(id_ex_bubble),
        .d(id_entry), .q(id_ex_q)
    );

    hazard_track_entry u_ex_mem (
        .clk(clk), .reset(reset), .load(1'b1), .bubble(1'b0),
        .d(id_ex_q), .q(ex_mem_q)
    );

    hazard_track_entry u_mem_wb (
        .clk(clk), .reset(reset), .load(1'b1), .bubble(1'b0),
        .d(ex_mem_q), .q(mem_wb_q)
    );

    // Halt sequencing: drain the pipe until the halt retires, then stay halted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RUN;
            halted    <= 1'b0;
            drain_cnt <= 8'd0;
        end else begin
            case (state)
                ST_RUN: begin
                    drain_cnt <= 8'd0;
                    if (halt_accept) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt <= drain_cnt + 8'd1;
                    if (halt_retired) begin
                        state  <= ST_HALTED;
                        halted <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // Saturating count of load-use stall cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= STALL_CNT_RESET;
        end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

    assign ex_mem_rd        = ex_mem_q.rd;
    assign ex_mem_reg_write = ex_mem_q.valid && ex_mem_q.reg_write;
    assign mem_wb_rd        = mem_wb_q.rd;
    assign mem_wb_reg_write = mem_wb_q.valid && mem_wb_q.reg_write;

    assign unused_bits = ^{ex_mem_q.mem_read, ex_mem_q.is_halt, mem_wb_q.mem_read};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: stalls, x0 loads, flush priority,
// halt drain timing, reset in the middle of work and counter saturation.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, id_is_halt;
    logic        ex_flush;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic [4:0]  ex_mem_rd, mem_wb_rd;
    logic        ex_mem_reg_write, mem_wb_reg_write, halted;
    logic [31:0] stall_cycles;

    logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble;
    logic [4:0]  s_ex_mem_rd, s_mem_wb_rd;
    logic        s_ex_mem_reg_write, s_mem_wb_reg_write, s_halted;
    logic [31:0] s_stall_cycles;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_is_halt(id_is_halt),
        .ex_flush(ex_flush), .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .ex_mem_rd(ex_mem_rd),
        .ex_mem_reg_write(ex_mem_reg_write), .mem_wb_rd(mem_wb_rd),
        .mem_wb_reg_write(mem_wb_reg_write), .halted(halted), .stall_cycles(stall_cycles)
    );

    pipe_hazard_ctrl #(.STALL_CNT_RESET(32'hFFFF_FFFD)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_is_halt(id_is_halt),
        .ex_flush(ex_flush), .pc_write(s_pc_write), .if_id_write(s_if_id_write),
        .if_id_flush(s_if_id_flush), .id_ex_bubble(s_id_ex_bubble), .ex_mem_rd(s_ex_mem_rd),
        .ex_mem_reg_write(s_ex_mem_reg_write), .mem_wb_rd(s_mem_wb_rd),
        .mem_wb_reg_write(s_mem_wb_reg_write), .halted(s_halted), .stall_cycles(s_stall_cycles)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic h);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr; id_is_halt = h;
        #1;
    endtask

    task automatic idle();
        ex_flush = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        checks++; if (pc_write !== 1'b1) begin failures++; $display("[TB] FAIL reset_pc_write got=%0b exp=1", pc_write); end
        checks++; if (ex_mem_rd !== 5'd0 || ex_mem_reg_write !== 1'b0) begin failures++; $display("[TB] FAIL reset_ex_mem got=%0d/%0b exp=0/0", ex_mem_rd, ex_mem_reg_write); end
        checks++; if (mem_wb_rd !== 5'd0 || mem_wb_reg_write !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_wb got=%0d/%0b exp=0/0", mem_wb_rd, mem_wb_reg_write); end
        checks++; if (halted !== 1'b0 || stall_cycles !== 32'd0) begin failures++; $display("[TB] FAIL reset_halt_cnt got=%0b/%0h exp=0/0", halted, stall_cycles); end
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw x5
        checks++; if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0) begin failures++; $display("[TB] FAIL lu_pre got=%0b/%0b exp=1/0", pc_write, id_ex_bubble); end
        step();
        set_id(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);   // add x6,x5,x7
        checks++; if (pc_write !== 1'b0 || if_id_write !== 1'b0 || id_ex_bubble !== 1'b1) begin failures++; $display("[TB] FAIL lu_stall got=%0b%0b%0b exp=001", pc_write, if_id_write, id_ex_bubble); end
        step();
        checks++; if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0) begin failures++; $display("[TB] FAIL lu_one_cycle got=%0b/%0b exp=1/0", pc_write, id_ex_bubble); end
        checks++; if (stall_cycles !== 32'd1) begin failures++; $display("[TB] FAIL lu_count got=%0d exp=1", stall_cycles); end
        checks++; if (ex_mem_rd !== 5'd5 || ex_mem_reg_write !== 1'b1) begin failures++; $display("[TB] FAIL lu_ex_mem got=%0d/%0b exp=5/1", ex_mem_rd, ex_mem_reg_write); end
        step();
        idle();
        checks++; if (ex_mem_reg_write !== 1'b0 || mem_wb_rd !== 5'd5 || mem_wb_reg_write !== 1'b1) begin failures++; $display("[TB] FAIL lu_bubble_adv got=%0b/%0d/%0b exp=0/5/1", ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write); end
        step();
        checks++; if (ex_mem_rd !== 5'd6 || ex_mem_reg_write !== 1'b1 || stall_cycles !== 32'd1) begin failures++; $display("[TB] FAIL lu_add_adv got=%0d/%0b/%0d exp=6/1/1", ex_mem_rd, ex_mem_reg_write, stall_cycles); end
    endtask

    task automatic test_x0_load();
        do_reset();
        set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);   // lw x0
        step();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);   // use x0
        checks++; if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0) begin failures++; $display("[TB] FAIL x0_no_stall got=%0b/%0b exp=1/0", pc_write, id_ex_bubble); end
        step();
        idle();
        checks++; if (stall_cycles !== 32'd0) begin failures++; $display("[TB] FAIL x0_count got=%0d exp=0", stall_cycles); end
        checks++; if (ex_mem_rd !== 5'd0 || ex_mem_reg_write !== 1'b1) begin failures++; $display("[TB] FAIL x0_passthru got=%0d/%0b exp=0/1", ex_mem_rd, ex_mem_reg_write); end
    endtask

    task automatic test_flush_priority();
        do_reset();
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        step();
        ex_flush = 1'b1;
        set_id(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        checks++; if (if_id_flush !== 1'b1 || pc_write !== 1'b1 || id_ex_bubble !== 1'b1) begin failures++; $display("[TB] FAIL fl_ctrl got=%0b%0b%0b exp=111", if_id_flush, pc_write, id_ex_bubble); end
        step();
        idle();
        checks++; if (stall_cycles !== 32'd0 || if_id_flush !== 1'b0) begin failures++; $display("[TB] FAIL fl_count got=%0d/%0b exp=0/0", stall_cycles, if_id_flush); end
        step();
        checks++; if (ex_mem_reg_write !== 1'b0) begin failures++; $display("[TB] FAIL fl_squashed got=%0b exp=0", ex_mem_reg_write); end
    endtask

    task automatic test_halt();
        do_reset();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);   // cycle N
        checks++; if (pc_write !== 1'b1) begin failures++; $display("[TB] FAIL halt_n got=%0b exp=1", pc_write); end
        step();
        set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        checks++; if (pc_write !== 1'b0 || if_id_write !== 1'b0 || id_ex_bubble !== 1'b1 || halted !== 1'b0) begin failures++; $display("[TB] FAIL halt_n1 got=%0b%0b%0b%0b exp=0010", pc_write, if_id_write, id_ex_bubble, halted); end
        step();
        checks++; if (pc_write !== 1'b0 || halted !== 1'b0) begin failures++; $display("[TB] FAIL halt_n2 got=%0b/%0b exp=0/0", pc_write, halted); end
        step();
        checks++; if (pc_write !== 1'b0 || halted !== 1'b0 || mem_wb_reg_write !== 1'b0) begin failures++; $display("[TB] FAIL halt_n3 got=%0b/%0b/%0b exp=0/0/0", pc_write, halted, mem_wb_reg_write); end
        step();
        checks++; if (halted !== 1'b1 || pc_write !== 1'b0 || if_id_write !== 1'b0) begin failures++; $display("[TB] FAIL halt_n4 got=%0b/%0b/%0b exp=1/0/0", halted, pc_write, if_id_write); end
        ex_flush = 1'b1;
        #1;
        checks++; if (pc_write !== 1'b0 || if_id_flush !== 1'b0) begin failures++; $display("[TB] FAIL halt_flush got=%0b/%0b exp=0/0", pc_write, if_id_flush); end
        step(); step();
        checks++; if (halted !== 1'b1 || ex_mem_reg_write !== 1'b0) begin failures++; $display("[TB] FAIL halt_sticky got=%0b/%0b exp=1/0", halted, ex_mem_reg_write); end
        idle();
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        step();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        step();
        idle();
        checks++; if (ex_mem_rd !== 5'd9 || pc_write !== 1'b0) begin failures++; $display("[TB] FAIL rd_setup got=%0d/%0b exp=9/0", ex_mem_rd, pc_write); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (ex_mem_rd !== 5'd0 || ex_mem_reg_write !== 1'b0 || mem_wb_reg_write !== 1'b0) begin failures++; $display("[TB] FAIL rd_async got=%0d/%0b/%0b exp=0/0/0", ex_mem_rd, ex_mem_reg_write, mem_wb_reg_write); end
        checks++; if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0 || halted !== 1'b0) begin failures++; $display("[TB] FAIL rd_run got=%0b/%0b/%0b exp=1/0/0", pc_write, id_ex_bubble, halted); end
        reset = 1'b0;
        step();
        checks++; if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin failures++; $display("[TB] FAIL rd_post got=%0b/%0b exp=1/1", pc_write, if_id_write); end
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0 || stall_cycles !== 32'd0) begin failures++; $display("[TB] FAIL rs_async got=%0b/%0b/%0d exp=1/0/0", pc_write, id_ex_bubble, stall_cycles); end
        reset = 1'b0;
        step();
        checks++; if (pc_write !== 1'b1 || stall_cycles !== 32'd0) begin failures++; $display("[TB] FAIL rs_post got=%0b/%0d exp=1/0", pc_write, stall_cycles); end
        idle();
    endtask

    task automatic test_saturation();
        logic [31:0] sat_exp [3];
        sat_exp[0] = 32'hFFFF_FFFE;
        sat_exp[1] = 32'hFFFF_FFFF;
        sat_exp[2] = 32'hFFFF_FFFF;
        do_reset();
        checks++; if (s_stall_cycles !== 32'hFFFF_FFFD) begin failures++; $display("[TB] FAIL sat_preset got=%0h exp=fffffffd", s_stall_cycles); end
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
            step();
            set_id(1'b1, 5'd1, 5'd3, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
            checks++; if (pc_write !== 1'b0) begin failures++; $display("[TB] FAIL sat_stall%0d got=%0b exp=0", i, pc_write); end
            step();
            checks++; if (s_stall_cycles !== sat_exp[i] || stall_cycles !== 32'(i + 1)) begin failures++; $display("[TB] FAIL sat_count%0d got=%0h/%0d exp=%0h/%0d", i, s_stall_cycles, stall_cycles, sat_exp[i], i + 1); end
            idle();
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        ex_flush = 1'b0;
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_rd = '0; id_reg_write = 1'b0; id_mem_read = 1'b0; id_is_halt = 1'b0;
        test_reset();
        test_load_use();
        test_x0_load();
        test_flush_priority();
        test_halt();
        test_reset_mid_op();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
